// File: rtl/spi_mux_ctrl.sv
// SPI frame controller for the LED output mux: command byte selects a channel,
// following data bytes are streamed to out with a one-cycle out_valid strobe.
module spi_mux_ctrl #(
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_nCS,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [7:0]        out,
   output logic              out_valid,
   output logic [NUM_CH-1:0] out_en,
   output logic              buffer_oe,
   output logic [2:0]        status
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
   localparam logic [2:0]    NUM_CH_W = 3'(NUM_CH);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_ERROR} state_t;

   state_t        state, state_nxt;
   logic          ncs_s1, ncs_s2, ncs_s3;
   logic          sck_s1, sck_s2, sck_s3;
   logic          mosi_s1, mosi_s2;
   logic          armed;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [6:0]    shift, shift_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [7:0]    miso_sh, miso_sh_nxt;
   logic [7:0]    out_nxt;
   logic          out_valid_nxt;
   logic [NUM_CH-1:0] out_en_nxt;
   logic          buffer_oe_nxt;
   logic [2:0]    status_nxt;
   logic          sck_rise, sck_fall, ncs_rise, byte_done;
   logic [7:0]    byte_val;

   // nCS stages reset low so a select held low across reset is not taken as a
   // new frame; armed only rises once nCS has been seen high after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {ncs_s1, ncs_s2, ncs_s3} <= '0;
         {sck_s1, sck_s2, sck_s3} <= '0;
         {mosi_s1, mosi_s2}       <= '0;
         armed                    <= 1'b0;
      end else begin
         {ncs_s1, ncs_s2, ncs_s3} <= {spi_nCS, ncs_s1, ncs_s2};
         {sck_s1, sck_s2, sck_s3} <= {spi_sck, sck_s1, sck_s2};
         {mosi_s1, mosi_s2}       <= {spi_mosi, mosi_s1};
         if (ncs_s2)
            armed <= 1'b1;
      end
   end

   assign sck_rise  = sck_s2 & ~sck_s3;
   assign sck_fall  = ~sck_s2 & sck_s3;
   assign ncs_rise  = ncs_s2 & ~ncs_s3;
   assign byte_val  = {shift, mosi_s2};
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign spi_miso  = (state == S_CMD) & miso_sh[7];

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      tcnt_nxt      = tcnt;
      miso_sh_nxt   = miso_sh;
      out_nxt       = out;
      out_valid_nxt = 1'b0;
      out_en_nxt    = out_en;
      buffer_oe_nxt = buffer_oe;
      status_nxt    = status;

      if (sck_rise) begin
         shift_nxt   = byte_val[6:0];
         bit_cnt_nxt = bit_cnt + 3'd1;
      end

      case (state)
         S_IDLE: begin
            bit_cnt_nxt   = '0;
            shift_nxt     = '0;
            tcnt_nxt      = '0;
            out_en_nxt    = '0;
            buffer_oe_nxt = 1'b0;
            if (armed && !ncs_s2) begin
               state_nxt   = S_CMD;
               miso_sh_nxt = {5'b0, status};
            end
         end
         S_CMD, S_DATA: begin
            if (sck_rise)
               tcnt_nxt = '0;
            else if (tcnt >= TMAX - TW'(1)) begin
               tcnt_nxt      = TMAX;
               state_nxt     = S_ERROR;
               status_nxt[2] = 1'b1;
               out_en_nxt    = '0;
               buffer_oe_nxt = 1'b0;
            end else
               tcnt_nxt = tcnt + TW'(1);

            if (state == S_CMD) begin
               if (sck_fall)
                  miso_sh_nxt = {miso_sh[6:0], 1'b0};
               if (byte_done) begin
                  if (byte_val[7] && ({1'b0, byte_val[1:0]} < NUM_CH_W)) begin
                     state_nxt     = S_DATA;
                     out_en_nxt    = {{(NUM_CH-1){1'b0}}, 1'b1} << byte_val[1:0];
                     buffer_oe_nxt = 1'b1;
                     status_nxt[0] = 1'b1;
                     if (byte_val[6])
                        status_nxt[2:1] = 2'b00;
                  end else begin
                     state_nxt     = S_ERROR;
                     status_nxt[1] = 1'b1;
                  end
               end
            end else if (byte_done) begin
               out_nxt       = byte_val;
               out_valid_nxt = 1'b1;
            end
         end
         default: begin
            out_en_nxt    = '0;
            buffer_oe_nxt = 1'b0;
         end
      endcase

      // Deselect overrides the state decision but keeps any byte completed in
      // the same cycle; only a truly partial byte flags a framing error.
      if ((state != S_IDLE) && ncs_rise) begin
         state_nxt     = S_IDLE;
         out_en_nxt    = '0;
         buffer_oe_nxt = 1'b0;
         status_nxt[0] = 1'b0;
         if ((bit_cnt != 3'd0) && !byte_done)
            status_nxt[2] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         tcnt      <= '0;
         miso_sh   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_en    <= '0;
         buffer_oe <= 1'b0;
         status    <= '0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         tcnt      <= tcnt_nxt;
         miso_sh   <= miso_sh_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
         out_en    <= out_en_nxt;
         buffer_oe <= buffer_oe_nxt;
         status    <= status_nxt;
      end
   end

endmodule

// File: tb/tb_spi_mux_ctrl.sv
// Scoreboard bench for spi_mux_ctrl: expected out bytes are queued as data
// bytes are sent and compared against strobes captured by a monitor.
module tb_spi_mux_ctrl;

   localparam int TMO = 1024;

   logic       clk = 1'b0, reset = 1'b1;
   logic       ncs = 1'b1, ncs2 = 1'b1, sck = 1'b0, mosi = 1'b0;
   logic       miso, out_valid, buffer_oe;
   logic [7:0] out;
   logic [3:0] out_en;
   logic [2:0] status;
   logic       miso2, out_valid2, buffer_oe2;
   logic [7:0] out2;
   logic [1:0] out_en2;
   logic [2:0] status2;

   int         checks = 0, failures = 0;
   int         rd_idx = 0, valid2_cnt = 0;
   logic [7:0] exp_q[$], got_q[$];
   logic [7:0] exp_b, m;

   always #5 clk = ~clk;

   spi_mux_ctrl #(.NUM_CH(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .spi_nCS(ncs), .spi_sck(sck), .spi_mosi(mosi),
      .spi_miso(miso), .out(out), .out_valid(out_valid), .out_en(out_en),
      .buffer_oe(buffer_oe), .status(status));

   spi_mux_ctrl #(.NUM_CH(2), .TIMEOUT(TMO)) dut2 (
      .clk(clk), .reset(reset), .spi_nCS(ncs2), .spi_sck(sck), .spi_mosi(mosi),
      .spi_miso(miso2), .out(out2), .out_valid(out_valid2), .out_en(out_en2),
      .buffer_oe(buffer_oe2), .status(status2));

   always @(negedge clk) begin
      if (out_valid) got_q.push_back(out);
      if (out_valid2) valid2_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // SCK = clk/8, mode 0; MISO captured at each rising edge.
   task automatic spi_xfer(input logic [7:0] b, input int n, output logic [7:0] mo);
      mo = '0;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         tick(4);
         mo[i] = miso;
         sck = 1'b1;
         tick(4);
         sck = 1'b0;
      end
   endtask

   task automatic frame_start();
      ncs = 1'b0;
      tick(8);
   endtask

   task automatic frame_end();
      ncs = 1'b1;
      tick(8);
   endtask

   task automatic test_reset();
      tick(3);
      checks++;
      if ({out, out_valid, out_en, buffer_oe, status, miso} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {out, out_valid, out_en, buffer_oe, status, miso});
      end
      reset = 1'b0;
      tick(4);
      checks++;
      if ({out_en, buffer_oe, status} !== 8'h00) begin
         failures++;
         $display("FAIL post_reset_idle got=%b exp=0", {out_en, buffer_oe, status});
      end
   endtask

   task automatic test_frame();
      frame_start();
      spi_xfer(8'h82, 8, m);
      checks++;
      if (m !== 8'h00) begin failures++; $display("FAIL frame_miso got=%h exp=00", m); end
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b0100, 1'b1, 3'b001}) begin
         failures++;
         $display("FAIL frame_cmd got=%b exp=%b", {out_en, buffer_oe, status}, {4'b0100, 1'b1, 3'b001});
      end
      exp_q.push_back(8'h5A); spi_xfer(8'h5A, 8, m);
      exp_q.push_back(8'hC3); spi_xfer(8'hC3, 8, m);
      frame_end();
      checks++;
      if ({out_en, buffer_oe, status, out} !== {4'b0, 1'b0, 3'b000, 8'hC3}) begin
         failures++;
         $display("FAIL frame_end got=%h exp=%h", {out_en, buffer_oe, status, out}, {4'b0, 1'b0, 3'b000, 8'hC3});
      end
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         checks++;
         if (rd_idx >= got_q.size()) begin
            failures++; $display("FAIL frame_out got=none exp=%h", exp_b);
         end else begin
            if (got_q[rd_idx] !== exp_b) begin
               failures++; $display("FAIL frame_out got=%h exp=%h", got_q[rd_idx], exp_b);
            end
            rd_idx++;
         end
      end
      checks++;
      if (got_q.size() != rd_idx) begin
         failures++; $display("FAIL frame_extra_valid got=%0d exp=0", got_q.size() - rd_idx);
         rd_idx = got_q.size();
      end
   endtask

   task automatic test_bad_command();
      frame_start();
      spi_xfer(8'h05, 8, m);
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b0, 1'b0, 3'b010}) begin
         failures++;
         $display("FAIL badcmd_state got=%b exp=%b", {out_en, buffer_oe, status}, {4'b0, 1'b0, 3'b010});
      end
      spi_xfer(8'h11, 8, m);
      spi_xfer(8'h22, 8, m);
      frame_end();
      checks++;
      if ({got_q.size() != rd_idx, status, out} !== {1'b0, 3'b010, 8'hC3}) begin
         failures++;
         $display("FAIL badcmd_data got=%h exp=%h", {got_q.size() != rd_idx, status, out}, {1'b0, 3'b010, 8'hC3});
         rd_idx = got_q.size();
      end
      // 0x83 is valid for four channels but out of range for two.
      ncs = 1'b0; ncs2 = 1'b0;
      tick(8);
      spi_xfer(8'h83, 8, m);
      checks++;
      if (m !== 8'h02) begin failures++; $display("FAIL badcmd_miso got=%h exp=02", m); end
      checks++;
      if ({out_en2, buffer_oe2, status2} !== {2'b00, 1'b0, 3'b010}) begin
         failures++;
         $display("FAIL badch_dut2 got=%b exp=%b", {out_en2, buffer_oe2, status2}, {2'b00, 1'b0, 3'b010});
      end
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b1000, 1'b1, 3'b011}) begin
         failures++;
         $display("FAIL ch3_dut got=%b exp=%b", {out_en, buffer_oe, status}, {4'b1000, 1'b1, 3'b011});
      end
      exp_q.push_back(8'h3C); spi_xfer(8'h3C, 8, m);
      ncs = 1'b1; ncs2 = 1'b1;
      tick(8);
      checks++;
      if (valid2_cnt != 0) begin failures++; $display("FAIL badch_valid got=%0d exp=0", valid2_cnt); end
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         checks++;
         if (rd_idx >= got_q.size()) begin
            failures++; $display("FAIL ch3_out got=none exp=%h", exp_b);
         end else begin
            if (got_q[rd_idx] !== exp_b) begin
               failures++; $display("FAIL ch3_out got=%h exp=%h", got_q[rd_idx], exp_b);
            end
            rd_idx++;
         end
      end
      checks++;
      if ({got_q.size() != rd_idx, status} !== {1'b0, 3'b010}) begin
         failures++;
         $display("FAIL ch3_end got=%b exp=%b", {got_q.size() != rd_idx, status}, {1'b0, 3'b010});
         rd_idx = got_q.size();
      end
   endtask

   task automatic test_partial_and_miso();
      frame_start();
      spi_xfer(8'h80, 8, m);
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b0001, 1'b1, 3'b011}) begin
         failures++;
         $display("FAIL partial_cmd got=%b exp=%b", {out_en, buffer_oe, status}, {4'b0001, 1'b1, 3'b011});
      end
      spi_xfer(8'hFF, 5, m);
      frame_end();
      checks++;
      if ({got_q.size() != rd_idx, status, out} !== {1'b0, 3'b110, 8'h3C}) begin
         failures++;
         $display("FAIL partial_end got=%h exp=%h", {got_q.size() != rd_idx, status, out}, {1'b0, 3'b110, 8'h3C});
         rd_idx = got_q.size();
      end
      frame_start();
      spi_xfer(8'hC0, 8, m);
      checks++;
      if (m !== 8'h06) begin failures++; $display("FAIL miso_status got=%h exp=06", m); end
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b0001, 1'b1, 3'b001}) begin
         failures++;
         $display("FAIL clear_cmd got=%b exp=%b", {out_en, buffer_oe, status}, {4'b0001, 1'b1, 3'b001});
      end
      exp_q.push_back(8'hA5); spi_xfer(8'hA5, 8, m);
      frame_end();
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         checks++;
         if (rd_idx >= got_q.size()) begin
            failures++; $display("FAIL clear_out got=none exp=%h", exp_b);
         end else begin
            if (got_q[rd_idx] !== exp_b) begin
               failures++; $display("FAIL clear_out got=%h exp=%h", got_q[rd_idx], exp_b);
            end
            rd_idx++;
         end
      end
      checks++;
      if ({got_q.size() != rd_idx, status} !== {1'b0, 3'b000}) begin
         failures++;
         $display("FAIL clear_end got=%b exp=%b", {got_q.size() != rd_idx, status}, {1'b0, 3'b000});
         rd_idx = got_q.size();
      end
   endtask

   task automatic test_timeout();
      int cyc;
      bit found;
      cyc = 0; found = 1'b0;
      frame_start();
      spi_xfer(8'h81, 8, m);
      checks++;
      if ({out_en, buffer_oe} !== {4'b0010, 1'b1}) begin
         failures++; $display("FAIL tmo_cmd got=%b exp=%b", {out_en, buffer_oe}, {4'b0010, 1'b1});
      end
      for (int c = 1; c <= TMO + 10; c++) begin
         tick(1);
         if (!found && !buffer_oe) begin found = 1'b1; cyc = c; end
      end
      checks++;
      if (!found || cyc < TMO - 3 || cyc > TMO + 1) begin
         failures++;
         $display("FAIL tmo_cycle got=%0d found=%0d exp=%0d..%0d", cyc, found, TMO - 3, TMO + 1);
      end
      checks++;
      if ({out_en, buffer_oe, status[2]} !== {4'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL tmo_state got=%b exp=%b", {out_en, buffer_oe, status[2]}, {4'b0, 1'b0, 1'b1});
      end
      spi_xfer(8'h77, 8, m);
      spi_xfer(8'h78, 8, m);
      frame_end();
      checks++;
      if ({got_q.size() != rd_idx, status, out} !== {1'b0, 3'b100, 8'hA5}) begin
         failures++;
         $display("FAIL tmo_end got=%h exp=%h", {got_q.size() != rd_idx, status, out}, {1'b0, 3'b100, 8'hA5});
         rd_idx = got_q.size();
      end
   endtask

   task automatic test_reset_mid_frame();
      frame_start();
      spi_xfer(8'h83, 8, m);
      checks++;
      if ({out_en, buffer_oe, status} !== {4'b1000, 1'b1, 3'b101}) begin
         failures++;
         $display("FAIL rst_cmd got=%b exp=%b", {out_en, buffer_oe, status}, {4'b1000, 1'b1, 3'b101});
      end
      spi_xfer(8'h12, 8, m);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({out, out_valid, out_en, buffer_oe, status, miso} !== '0) begin
         failures++;
         $display("FAIL rst_async got=%h exp=0", {out, out_valid, out_en, buffer_oe, status, miso});
      end
      tick(2);
      reset = 1'b0;
      rd_idx = got_q.size();
      tick(8);
      spi_xfer(8'h81, 8, m);
      spi_xfer(8'h44, 8, m);
      checks++;
      if ({got_q.size() != rd_idx, out, out_en, buffer_oe, status} !== '0) begin
         failures++;
         $display("FAIL rst_ignored got=%h exp=0", {got_q.size() != rd_idx, out, out_en, buffer_oe, status});
         rd_idx = got_q.size();
      end
      frame_end();
      frame_start();
      spi_xfer(8'h81, 8, m);
      checks++;
      if ({m, out_en, buffer_oe} !== {8'h00, 4'b0010, 1'b1}) begin
         failures++;
         $display("FAIL rst_newframe got=%h exp=%h", {m, out_en, buffer_oe}, {8'h00, 4'b0010, 1'b1});
      end
      exp_q.push_back(8'h6B); spi_xfer(8'h6B, 8, m);
      frame_end();
      while (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         checks++;
         if (rd_idx >= got_q.size()) begin
            failures++; $display("FAIL rst_out got=none exp=%h", exp_b);
         end else begin
            if (got_q[rd_idx] !== exp_b) begin
               failures++; $display("FAIL rst_out got=%h exp=%h", got_q[rd_idx], exp_b);
            end
            rd_idx++;
         end
      end
      checks++;
      if ({got_q.size() != rd_idx, status, out} !== {1'b0, 3'b000, 8'h6B}) begin
         failures++;
         $display("FAIL rst_end got=%h exp=%h", {got_q.size() != rd_idx, status, out}, {1'b0, 3'b000, 8'h6B});
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_bad_command();
      test_partial_and_miso();
      test_timeout();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_mux_ctrl.md
Name: spi_mux_ctrl

Overview:
- Frame controller for the SPI LED-output mux; replaces the SPI-clocked latch path with fully synchronous logic in the clk domain.
- Samples nCS/SCK/MOSI, decodes a command byte that selects one of NUM_CH output channels and drives the one-hot out_en and buffer_oe.
- Streams the following data bytes to the 8-bit out bus with a one-cycle out_valid strobe, and reports frame status.
- Sits between the SPI pins and the output buffer/enable network.

Parameters:
- NUM_CH, 4, number of output channels; one-hot width of out_en (2..4; channel field is 2 bits).
- TIMEOUT, 1024, clk cycles without an SCK rising edge while nCS is low before the frame is aborted.

Ports:
- clk  input  1  system clock; SCK must be at most clk/4.
- reset  input  1  asynchronous, active-high reset.
- spi_nCS  input  1  SPI chip select, active low, asynchronous to clk.
- spi_sck  input  1  SPI clock, mode 0, asynchronous to clk.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_miso  output  1  status byte shifted out during the command byte; 0 otherwise.
- out  output  8  last complete data byte.
- out_valid  output  1  one-cycle strobe when out updates.
- out_en  output  NUM_CH  one-hot selected channel; all zero when no frame is active.
- buffer_oe  output  1  output buffer enable; 1 only in DATA state.
- status  output  3  [0] frame active, [1] sticky bad-channel, [2] sticky framing/timeout error.

Behaviour:
- Reset (async, active-high): state IDLE; out=0, out_valid=0, out_en=0, buffer_oe=0, status=0, spi_miso=0; bit counter, shift register and timeout counter cleared.
- Input sampling:
  - 2-FF synchronizer on each of nCS, SCK and MOSI, plus a third SCK/nCS stage for edge detection.
  - sck_rise and sck_fall are single-cycle pulses derived from the synchronized signals.
  - sck_rise shifts MOSI into shift[0] (shift left) and increments the 3-bit bit counter; the counter wraps 7->0 on byte completion.
- States:
  - IDLE: wait for synchronized nCS = 0 -> CMD; bit counter and timeout counter cleared.
  - CMD, completion of the 8th bit (byte B):
    - B[7]=1 and B[1:0] < NUM_CH -> DATA; out_en = 1<<B[1:0]; buffer_oe=1; status[0]=1.
    - B[6]=1 also clears status[2:1] in the same cycle.
    - Otherwise -> ERROR and status[1] set.
  - DATA: each completed byte -> out=byte and out_valid=1 for exactly one cycle. Both take effect on the clk edge after the cycle in which the 8th sck_rise of that byte is detected.
  - ERROR: out_en=0, buffer_oe=0, completed bytes ignored; stays until synchronized nCS = 1.
- nCS deassert (synchronized rising edge) from any non-IDLE state:
  - -> IDLE; out_en=0, buffer_oe=0, status[0]=0 on the next clk edge.
  - If the bit counter != 0 (partial byte), set status[2]; the partial byte is discarded and out is unchanged.
- Simultaneous events:
  - nCS rise in the same cycle as an 8th-bit sck_rise: the byte completes first (out/out_valid updated), then IDLE.
  - Byte completion and timeout never coincide; any sck_rise resets the timeout counter.
- Timeout:
  - In CMD or DATA, the counter increments each cycle without sck_rise; reaching TIMEOUT -> ERROR, status[2] set, out_en=0, buffer_oe=0.
  - Counter saturates and holds in ERROR.
- MISO:
  - In CMD, loads {5'b0,status} at nCS assert; shifts out MSB first, updated on sck_fall.
  - Bit 7 is valid before the first SCK rise.
  - Driven 0 in IDLE, DATA and ERROR.
- Stickiness: status[2:1] persist across frames until cleared by a valid command with B[6]=1, or by reset.
- out holds its value between frames; out is never cleared except by reset.
- reset mid-frame: immediate return to reset values; the frame is not resumed even if nCS remains low (a new nCS falling edge is required).

Test Plan:
- Send frame 0x82,0x5A,0xC3 at SCK=clk/8 -> out_en=4'b0100 and buffer_oe=1 after the command byte; out=0x5A then 0xC3, each with a single out_valid pulse; after nCS high, out_en=0, buffer_oe=0, status=3'b000, out=0xC3.
- Command 0x05 (bit7=0) or with NUM_CH=2 command 0x83 -> ERROR, out_en=0, status[1]=1; following data bytes produce no out_valid.
- Frame 0x80 then 5 bits then nCS high -> status[2]=1, out unchanged; next frame with command 0xC0 -> status[2:1]=0, out_en=4'b0001.
- nCS low, command 0x81 sent, SCK stopped for TIMEOUT+10 cycles -> ERROR at cycle TIMEOUT, buffer_oe=0, status[2]=1; SCK resumes with no out_valid until nCS is toggled.
- With status=3'b110 from earlier errors, new frame -> MISO bits read on SCK rises during the command byte = 0x06.
- Assert reset while in DATA with nCS held low -> all outputs 0 immediately; SCK bytes ignored until nCS goes high then low again.
